// File: rtl/leve1_axir_arb_pkg.sv
// Shared types for the LEVE1 AXI read-initiator arbiter: FSM states, AXI burst
// encodings and the default-width AR request record.
package leve1_axir_arb_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        axi_burst_t            burst;
        logic [AXI_LEN_W-1:0]  len;
    } ar_req_t;

endpackage

// File: rtl/leve1_axir_arb_arb2.sv
// Two-input grant logic: fixed S1-over-S0 priority, or round-robin with a
// last-grant pointer when LEVE1_AXIR_ARB_RR_EN is defined.
module leve1_axir_arb_arb2 (
`ifdef LEVE1_AXIR_ARB_RR_EN
    input  logic CLK,
    input  logic RSTn,
    input  logic grant,
    input  logic req0,
`endif
    input  logic req1,
    output logic winner
);

`ifdef LEVE1_AXIR_ARB_RR_EN
    logic last_q;

    // Pointer starts at 1 so requester 0 wins the very first tie.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= winner;
        end
    end

    always_comb begin
        winner = (req0 && req1) ? ~last_q : req1;
    end
`else
    always_comb begin
        winner = req1;
    end
`endif

endmodule

// File: rtl/leve1_axir_arb.sv
// Shares one AXI read initiator between ifetch (S0) and LSU (S1), one burst at a time.
// Define LEVE1_AXIR_ARB_RR_EN for round-robin instead of fixed S1-over-S0 priority.
module leve1_axir_arb
    import leve1_axir_arb_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = 128,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              S0_ARVALID,
    output logic              S0_ARREADY,
    input  logic [ADDR_W-1:0] S0_ARADDR,
    input  logic [1:0]        S0_ARBURST,
    input  logic [LEN_W-1:0]  S0_ARLEN,
    output logic              S0_RVALID,
    input  logic              S0_RREADY,
    output logic [DATA_W-1:0] S0_RDATA,
    output logic              S0_RLAST,
    input  logic              S1_ARVALID,
    output logic              S1_ARREADY,
    input  logic [ADDR_W-1:0] S1_ARADDR,
    input  logic [1:0]        S1_ARBURST,
    input  logic [LEN_W-1:0]  S1_ARLEN,
    output logic              S1_RVALID,
    input  logic              S1_RREADY,
    output logic [DATA_W-1:0] S1_RDATA,
    output logic              S1_RLAST,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    output logic [ADDR_W-1:0] M_ARADDR,
    output logic [1:0]        M_ARBURST,
    output logic [LEN_W-1:0]  M_ARLEN,
    input  logic              M_RVALID,
    output logic              M_RREADY,
    input  logic [DATA_W-1:0] M_RDATA,
    input  logic              M_RLAST
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        axi_burst_t        burst;
        logic [LEN_W-1:0]  len;
    } hold_t;

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    hold_t      hold_q, hold_d;
    hold_t      s0_req, s1_req;
    logic       winner;

    assign s0_req = '{addr: S0_ARADDR, burst: axi_burst_t'(S0_ARBURST), len: S0_ARLEN};
    assign s1_req = '{addr: S1_ARADDR, burst: axi_burst_t'(S1_ARBURST), len: S1_ARLEN};

`ifdef LEVE1_AXIR_ARB_RR_EN
    logic grant;
    assign grant = (state_q == IDLE) && (S0_ARVALID || S1_ARVALID);

    leve1_axir_arb_arb2 u_arb (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .grant  (grant),
        .req0   (S0_ARVALID),
        .req1   (S1_ARVALID),
        .winner (winner)
    );
`else
    leve1_axir_arb_arb2 u_arb (
        .req1   (S1_ARVALID),
        .winner (winner)
    );
`endif

    // Holding registers reset to zero so the downstream AR fields read 0 out of reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    assign M_ARADDR  = hold_q.addr;
    assign M_ARBURST = hold_q.burst;
    assign M_ARLEN   = hold_q.len;

    // NOTE: every output and next-state term gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        M_ARVALID  = 1'b0;
        M_RREADY   = 1'b0;
        S0_ARREADY = 1'b0;
        S1_ARREADY = 1'b0;
        S0_RVALID  = 1'b0;
        S1_RVALID  = 1'b0;
        S0_RLAST   = 1'b0;
        S1_RLAST   = 1'b0;
        S0_RDATA   = '0;
        S1_RDATA   = '0;
        unique case (state_q)
            IDLE: begin
                if (S0_ARVALID || S1_ARVALID) begin
                    owner_d = winner;
                    hold_d  = winner ? s1_req : s0_req;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) begin
                    S0_ARREADY = ~owner_q;
                    S1_ARREADY = owner_q;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (owner_q) begin
                    S1_RVALID = M_RVALID;
                    S1_RDATA  = M_RDATA;
                    S1_RLAST  = M_RLAST;
                    M_RREADY  = S1_RREADY;
                end else begin
                    S0_RVALID = M_RVALID;
                    S0_RDATA  = M_RDATA;
                    S0_RLAST  = M_RLAST;
                    M_RREADY  = S0_RREADY;
                end
                if (M_RVALID && M_RREADY && M_RLAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_leve1_axir_arb.sv
// Randomized bench for leve1_axir_arb: two random requesters and a random downstream memory,
// checked against a transaction-level reference (set LEVE1_AXIR_ARB_RR_EN to match the RTL build).
module tb_leve1_axir_arb;
    import leve1_axir_arb_pkg::*;

    localparam int ADDR_W = AXI_ADDR_W;
    localparam int DATA_W = 128;
    localparam int LEN_W  = AXI_LEN_W;
    localparam int NCYC   = 4000;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              S0_ARVALID, S0_ARREADY, S0_RVALID, S0_RREADY, S0_RLAST;
    logic [ADDR_W-1:0] S0_ARADDR;
    logic [1:0]        S0_ARBURST;
    logic [LEN_W-1:0]  S0_ARLEN;
    logic [DATA_W-1:0] S0_RDATA;
    logic              S1_ARVALID, S1_ARREADY, S1_RVALID, S1_RREADY, S1_RLAST;
    logic [ADDR_W-1:0] S1_ARADDR;
    logic [1:0]        S1_ARBURST;
    logic [LEN_W-1:0]  S1_ARLEN;
    logic [DATA_W-1:0] S1_RDATA;
    logic              M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
    logic [ADDR_W-1:0] M_ARADDR;
    logic [1:0]        M_ARBURST;
    logic [LEN_W-1:0]  M_ARLEN;
    logic [DATA_W-1:0] M_RDATA;

    always #5 CLK = ~CLK;

    // Requester-indexed views of the two slave ports.
    logic [1:0]        arvalid, rready;
    ar_req_t           ar_drv [2];
    logic [1:0]        arready_o, rvalid_o, rlast_o;
    logic [DATA_W-1:0] rdata_o [2];

    assign S0_ARVALID = arvalid[0];
    assign S1_ARVALID = arvalid[1];
    assign S0_ARADDR  = ar_drv[0].addr;
    assign S1_ARADDR  = ar_drv[1].addr;
    assign S0_ARBURST = ar_drv[0].burst;
    assign S1_ARBURST = ar_drv[1].burst;
    assign S0_ARLEN   = ar_drv[0].len;
    assign S1_ARLEN   = ar_drv[1].len;
    assign S0_RREADY  = rready[0];
    assign S1_RREADY  = rready[1];
    assign arready_o  = {S1_ARREADY, S0_ARREADY};
    assign rvalid_o   = {S1_RVALID, S0_RVALID};
    assign rlast_o    = {S1_RLAST, S0_RLAST};
    assign rdata_o[0] = S0_RDATA;
    assign rdata_o[1] = S1_RDATA;

    leve1_axir_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY), .S0_ARADDR(S0_ARADDR),
        .S0_ARBURST(S0_ARBURST), .S0_ARLEN(S0_ARLEN), .S0_RVALID(S0_RVALID),
        .S0_RREADY(S0_RREADY), .S0_RDATA(S0_RDATA), .S0_RLAST(S0_RLAST),
        .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY), .S1_ARADDR(S1_ARADDR),
        .S1_ARBURST(S1_ARBURST), .S1_ARLEN(S1_ARLEN), .S1_RVALID(S1_RVALID),
        .S1_RREADY(S1_RREADY), .S1_RDATA(S1_RDATA), .S1_RLAST(S1_RLAST),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARBURST(M_ARBURST), .M_ARLEN(M_ARLEN), .M_RVALID(M_RVALID),
        .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RLAST(M_RLAST)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] addr, input int beat);
        logic [31:0] b;
        b = beat;
        return {addr ^ 32'hA5A5_0F0F, b, ~addr, addr + b};
    endfunction

    // Requesters, downstream memory and transaction-level reference state.
    ar_req_t    req_cur [2];
    logic [1:0] req_active, req_wait;
    int         beat_cnt [2];
    bit         ds_active, ds_hold;
    ar_req_t    ds_req;
    int         ds_beat;
    bit         arb_free, ar_pending, in_data;
    int         exp_owner, data_owner;
    ar_req_t    exp_req;
    int         bursts;
`ifdef LEVE1_AXIR_ARB_RR_EN
    bit         rr_last;
`endif

    task automatic clear_all();
        req_active = '0;
        req_wait   = '0;
        arvalid    = '0;
        rready     = '0;
        ar_drv[0]  = '0;
        ar_drv[1]  = '0;
        M_ARREADY  = 1'b0;
        M_RVALID   = 1'b0;
        M_RDATA    = '0;
        M_RLAST    = 1'b0;
        ds_active  = 1'b0;
        ds_hold    = 1'b0;
        arb_free   = 1'b1;
        ar_pending = 1'b0;
        in_data    = 1'b0;
`ifdef LEVE1_AXIR_ARB_RR_EN
        rr_last    = 1'b1;
`endif
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (!req_active[r] && !req_wait[r] && $urandom_range(0, 99) < 35) begin
                req_cur[r].addr  = $urandom & 32'hFFFF_FFF0;
                req_cur[r].burst = axi_burst_t'(2'($urandom_range(0, 2)));
                req_cur[r].len   = ($urandom_range(0, 3) == 0) ? '0 : AXI_LEN_W'($urandom_range(1, 7));
                req_active[r]    = 1'b1;
                beat_cnt[r]      = 0;
            end
            rready[r] = ($urandom_range(0, 99) < 70);
            ar_drv[r] = req_active[r] ? req_cur[r] : '0;
        end
        arvalid   = req_active;
        M_ARREADY = ($urandom_range(0, 1) == 1);
        if (ds_active) begin
            if (!ds_hold) M_RVALID = ($urandom_range(0, 99) < 60);
            M_RDATA = beat_data(ds_req.addr, ds_beat);
            M_RLAST = (ds_beat == int'(ds_req.len));
        end else begin
            // Stray beats while no burst is accepted must never reach a requester.
            M_RVALID = ($urandom_range(0, 9) == 0);
            M_RDATA  = {$urandom, $urandom, $urandom, $urandom};
            M_RLAST  = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic observe();
        bit was_free;
        bit hs;
        int o;
        was_free = arb_free;
        if (in_data) begin
            o = data_owner;
            check("r_valid", rvalid_o[o], M_RVALID);
            check("r_data", rdata_o[o], M_RDATA);
            check("r_last", rlast_o[o], M_RLAST);
            check("m_rready", M_RREADY, rready[o]);
            check("r_other", {rvalid_o[1-o], rlast_o[1-o]}, 2'b00);
            check("r_other_data", rdata_o[1-o], '0);
            hs = M_RVALID && rready[o];
            if (hs) begin
                check("beat_data", rdata_o[o], beat_data(req_cur[o].addr, beat_cnt[o]));
                check("beat_last", rlast_o[o], beat_cnt[o] == int'(req_cur[o].len));
                beat_cnt[o]++;
                ds_beat++;
                if (M_RLAST) begin
                    in_data     = 1'b0;
                    arb_free    = 1'b1;
                    req_wait[o] = 1'b0;
                    ds_active   = 1'b0;
                    bursts++;
                end
            end
            ds_hold = M_RVALID && !hs;
        end else begin
            check("r_quiet", {M_RREADY, rvalid_o, rlast_o}, 5'b0);
            check("r_quiet_data", rdata_o[0] | rdata_o[1], '0);
            ds_hold = 1'b0;
        end
        if (ar_pending) begin
            check("m_arvalid", M_ARVALID, 1'b1);
            check("m_araddr", M_ARADDR, exp_req.addr);
            check("m_arburst", M_ARBURST, exp_req.burst);
            check("m_arlen", M_ARLEN, exp_req.len);
            check("s_arready", arready_o, M_ARREADY ? (exp_owner == 1 ? 2'b10 : 2'b01) : 2'b00);
            if (M_ARREADY) begin
                ar_pending            = 1'b0;
                in_data               = 1'b1;
                data_owner            = exp_owner;
                req_active[exp_owner] = 1'b0;
                req_wait[exp_owner]   = 1'b1;
                ds_active             = 1'b1;
                ds_req                = exp_req;
                ds_beat               = 0;
                ds_hold               = 1'b0;
            end
        end else begin
            check("ar_quiet", {M_ARVALID, arready_o}, 3'b000);
        end
        // A free arbiter that sees a request this cycle presents it downstream next cycle.
        if (was_free && req_active != 2'b00) begin
            int w;
`ifdef LEVE1_AXIR_ARB_RR_EN
            w = (req_active == 2'b11) ? int'(!rr_last) : int'(req_active[1]);
            rr_last = w[0];
`else
            w = int'(req_active[1]);
`endif
            exp_owner  = w;
            exp_req    = req_cur[w];
            ar_pending = 1'b1;
            arb_free   = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ar"}, {M_ARVALID, arready_o}, 3'b000);
        check({tag, "_r"}, {M_RREADY, rvalid_o, rlast_o}, 5'b0);
        check({tag, "_rdata"}, rdata_o[0] | rdata_o[1], '0);
    endtask

    initial begin
        bit did_reset;
        did_reset = 1'b0;
        bursts    = 0;
        RSTn      = 1'b1;
        clear_all();
        // Busy-looking inputs during reset: outputs must still all be 0.
        arvalid   = 2'b11;
        ar_drv[0] = '{addr: 32'h8000_0010, burst: BURST_WRAP, len: 8'd3};
        ar_drv[1] = '{addr: 32'h1234_5670, burst: BURST_INCR, len: 8'd1};
        rready    = 2'b11;
        M_ARREADY = 1'b1;
        M_RVALID  = 1'b1;
        M_RLAST   = 1'b1;
        M_RDATA   = {4{32'hDEAD_BEEF}};
        #3 RSTn = 1'b0;
        #9;
        check_all_zero("reset");
        check("reset_ar_fields", {M_ARADDR, M_ARBURST, M_ARLEN}, '0);
        clear_all();
        @(posedge CLK);
        #3 RSTn = 1'b1;
        @(posedge CLK);
        #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drive();
            @(negedge CLK);
            observe();
            if (!did_reset && cyc > 1500 && in_data && beat_cnt[data_owner] == 1) begin
                did_reset = 1'b1;
                #2 RSTn = 1'b0;
                #1;
                check_all_zero("midburst_reset");
                clear_all();
                @(posedge CLK);
                #3 RSTn = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        check("progress", bursts > 50, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leve1_axir_arb.md
Name: leve1_axir_arb

Overview:
- Two-requester arbiter that shares one AXI read initiator port between the instruction fetch unit (requester 0) and the load/data unit (requester 1).
- Owns AR-channel arbitration and routes the R channel back to the current owner. Only one burst is outstanding at a time, with no reordering.
- Sits between the LEVE1 front-end/LSU and the memory-side AXI read interconnect.

Parameters:
- ADDR_W, 32, AR address width
- DATA_W, 128, R data width
- LEN_W, 8, ARLEN width

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- S0_ARVALID  in  1  requester 0 (ifetch) address valid
- S0_ARREADY  out  1  requester 0 address accepted
- S0_ARADDR  in  ADDR_W  requester 0 address
- S0_ARBURST  in  2  requester 0 burst type
- S0_ARLEN  in  LEN_W  requester 0 beats minus 1
- S0_RVALID  out  1  requester 0 read data valid
- S0_RREADY  in  1  requester 0 data ready
- S0_RDATA  out  DATA_W  requester 0 read data
- S0_RLAST  out  1  requester 0 last beat
- S1_*  (same set as S0_*)  requester 1 (LSU)
- M_ARVALID  out  1  downstream address valid
- M_ARREADY  in  1  downstream address ready
- M_ARADDR  out  ADDR_W  downstream address
- M_ARBURST  out  2  downstream burst type
- M_ARLEN  out  LEN_W  downstream length
- M_RVALID  in  1  downstream data valid
- M_RREADY  out  1  downstream data ready
- M_RDATA  in  DATA_W  downstream data
- M_RLAST  in  1  downstream last beat

Behaviour:
- Reset values: state=IDLE, owner=0, and all outputs 0. This includes M_ARVALID, M_RREADY, S*_ARREADY and S*_RVALID.
- IDLE:
  - If any S*_ARVALID is high, pick a winner, register owner, and latch its ARADDR/ARBURST/ARLEN into holding registers. Go to ADDR.
  - Default policy is fixed priority: S1 beats S0, so the LSU wins when both request.
  - S*_ARREADY is 0 in IDLE.
- ADDR:
  - M_ARVALID=1, driven from the holding registers.
  - When M_ARVALID && M_ARREADY, assert S{owner}_ARREADY=1 in that same cycle and go to DATA.
  - Requesters must hold ARVALID and their AR fields stable until ARREADY, per AXI.
- DATA:
  - S{owner}_RVALID=M_RVALID, S{owner}_RDATA=M_RDATA, S{owner}_RLAST=M_RLAST, M_RREADY=S{owner}_RREADY.
  - The non-owner sees RVALID=0, RLAST=0 and RDATA=0.
  - On the M_RVALID && M_RREADY && M_RLAST handshake, go to IDLE.
- Latency:
  - A request first seen in cycle N gives M_ARVALID in cycle N+1.
  - The next arbitration happens in the cycle after RLAST, so there is a 1-cycle bubble between bursts.
- A request arriving while busy waits. It is never dropped or reordered.
- M_ARVALID deasserts in the cycle after the AR handshake; it never stays high for 2 handshakes.
- ARLEN=0 (single beat) is legal: RLAST on the first beat returns the block to IDLE.
- If RVALID arrives while in ADDR (protocol violation): M_RREADY=0 and the data is ignored.
- Asynchronous reset mid-burst returns the block to IDLE immediately and all valids go to 0. The downstream port must be reset by the same RSTn.

Optional Feature:
- Macro: LEVE1_AXIR_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register is updated on each grant; when both requesters are valid in IDLE, the one not granted last wins. last-grant resets to 1, so S0 wins the first tie.
- Undefined: fixed priority, S1 over S0. No last-grant register exists.

Decomposition:
- Shared package (e.g. leve1_axi_pkg):
  - arb_state_t enum {IDLE, ADDR, DATA}
  - AXI burst constants (FIXED/INCR/WRAP)
  - an ar_req_t struct {addr, burst, len}
- Optional sub-module leve1_arb2: a 2-input arbiter, combinational grant plus the optional round-robin pointer. The FSM and muxing stay in the top module.

Test Plan:
- Single S0 WRAP request, ARADDR=0x8000_0010, ARLEN=3, M_ARREADY=1 -> M_ARVALID 1 cycle later with same fields; 4 beats routed to S0, S0_RLAST on beat 4; S1_RVALID stays 0.
- S0 and S1 both assert in the same cycle:
  - Fixed priority: S1 granted first, S0 second after S1 RLAST plus 1 idle cycle.
  - RR_EN build: grants alternate S0, S1, S0 over 3 consecutive ties.
- M_ARREADY held low 5 cycles -> M_ARVALID and fields stable; S*_ARREADY 0 until the handshake cycle.
- S0 drops RREADY for 3 cycles mid-burst -> M_RREADY low for those cycles; no beat lost or duplicated (check a data sequence 0..3).
- ARLEN=0 from S1 -> one beat with RLAST; back in IDLE the next cycle; a pending S0 request is granted immediately after.
- RSTn asserted during beat 2 of a 4-beat burst -> all outputs 0 asynchronously; after release, a new S0 request completes normally.
